// File: rtl/ahb_regfile_slave.sv
// AHB-Lite slave with a small word-addressed register file.
// Register 0 is a read-only ID word. Every OKAY transfer spends WAIT_STATES
// stall cycles before its data phase. Illegal accesses get a two-cycle ERROR
// response and never touch the registers.
module ahb_regfile_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_STATES = 1,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA4B0_0001
) (
  input  logic                        hclk,
  input  logic                        hreset,
  input  logic                        hsel,
  input  logic [ADDR_WIDTH-1:0]       haddr,
  input  logic [1:0]                  htrans,
  input  logic                        hwrite,
  input  logic [2:0]                  hsize,
  input  logic [2:0]                  hburst,
  input  logic [DATA_WIDTH-1:0]       hwdata,
  input  logic                        hready,
  output logic                        hready_resp,
  output logic [1:0]                  hresp,
  output logic [DATA_WIDTH-1:0]       hrdata,
  output logic                        wr_pulse,
  output logic [$clog2(NUM_REGS)-1:0] wr_idx
);

  localparam int IDX_W = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t state, next_state;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [IDX_W-1:0] idx_q;
  logic [1:0]       off_q;
  logic [2:0]       size_q;
  logic             write_q;
  logic [2:0]       wait_cnt;

  logic       accept;
  logic       illegal;
  logic [11:0] window_hi;
  logic [3:0] lane_en;
  logic       commit;

  // Burst type and the upper address bits are deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{hburst, htrans[0], haddr[ADDR_WIDTH-1:12]};

  // A new address phase is taken only for NONSEQ/SEQ while the bus is ready.
  assign accept    = hsel & hready & htrans[1];
  assign window_hi = haddr[11:0] >> (2 + IDX_W);
  assign illegal   = (hsize > 3'd2)
                   | ((hsize == 3'd1) & haddr[0])
                   | ((hsize == 3'd2) & (haddr[1:0] != 2'b00))
                   | (window_hi != 12'd0);

  // Register writes land on the edge that ends DATA; register 0 is never written.
  assign commit = (state == ST_DATA) & write_q & (idx_q != '0);

  // Byte lanes touched by the latched transfer size and offset.
  always_comb begin
    lane_en = 4'b0000;
    case (size_q)
      3'd0:    lane_en[off_q] = 1'b1;
      3'd1:    lane_en = off_q[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  // State register.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; IDLE, DATA and ERR2 can all take a pipelined address.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept) begin
          if (illegal) begin
            next_state = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            next_state = ST_WAIT;
          end else begin
            next_state = ST_DATA;
          end
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 3'd0) begin
          next_state = ST_DATA;
        end
      end
      ST_ERR1: next_state = ST_ERR2;
      default: next_state = ST_IDLE;
    endcase
  end

  // Response outputs decoded from the current state.
  always_comb begin
    hready_resp = 1'b1;
    hresp       = 2'b00;
    hrdata      = '0;
    case (state)
      ST_WAIT: hready_resp = 1'b0;
      ST_DATA: begin
        if (!write_q) begin
          hrdata = regs[idx_q];
        end
      end
      ST_ERR1: begin
        hready_resp = 1'b0;
        hresp       = 2'b01;
      end
      ST_ERR2: hresp = 2'b01;
      default: ;
    endcase
  end

  // Capture the address-phase controls of each accepted transfer.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      idx_q   <= '0;
      off_q   <= 2'b00;
      size_q  <= 3'd0;
      write_q <= 1'b0;
    end else if (accept && ((state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2))) begin
      idx_q   <= haddr[2 +: IDX_W];
      off_q   <= haddr[1:0];
      size_q  <= hsize;
      write_q <= hwrite;
    end
  end

  // Wait-state counter, loaded on entry to WAIT and counted down inside it.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      wait_cnt <= 3'd0;
    end else if ((state != ST_WAIT) && (next_state == ST_WAIT)) begin
      wait_cnt <= 3'(WAIT_STATES - 1);
    end else if ((state == ST_WAIT) && (wait_cnt != 3'd0)) begin
      wait_cnt <= wait_cnt - 3'd1;
    end
  end

  // Register file with lane-merged writes and a constant ID word at index 0.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == 0) ? ID_VALUE : '0;
      end
    end else if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) begin
          regs[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
        end
      end
    end
  end

  // One-cycle strobe reporting which register was just written.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      wr_pulse <= 1'b0;
      wr_idx   <= '0;
    end else begin
      wr_pulse <= commit;
      if (commit) begin
        wr_idx <= idx_q;
      end
    end
  end

endmodule

// File: tb/tb_ahb_regfile_slave.sv
// Self-checking bench for ahb_regfile_slave: a pipelined bus driver pushes
// expected responses into a scoreboard, a monitor pops and compares them.
module tb_ahb_regfile_slave;

  localparam int WS       = 1;
  localparam int NUM_REGS = 16;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic        hready_resp;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic        wr_pulse;
  logic [3:0]  wr_idx;

  // Only one slave on this bus, so the muxed ready is this slave's ready.
  assign hready = hready_resp;

  always #5 hclk = ~hclk;

  ahb_regfile_slave #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .NUM_REGS   (NUM_REGS),
    .WAIT_STATES(WS),
    .ID_VALUE   (32'hA4B0_0001)
  ) dut (
    .hclk       (hclk),
    .hreset     (hreset),
    .hsel       (hsel),
    .haddr      (haddr),
    .htrans     (htrans),
    .hwrite     (hwrite),
    .hsize      (hsize),
    .hburst     (hburst),
    .hwdata     (hwdata),
    .hready     (hready),
    .hready_resp(hready_resp),
    .hresp      (hresp),
    .hrdata     (hrdata),
    .wr_pulse   (wr_pulse),
    .wr_idx     (wr_idx)
  );

  typedef struct {
    bit          wr;
    bit          err;
    logic [31:0] rdata;
    logic [3:0]  idx;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model [NUM_REGS];
  int          compared   = 0;
  int          mismatched = 0;
  bit          mon_en     = 1'b0;
  bit          active     = 1'b0;
  int          cyc        = 0;
  exp_t        cur;
  bit          exp_pulse  = 1'b0;
  logic [3:0]  exp_idx    = 4'd0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] laneMask(input logic [2:0] size, input logic [1:0] off);
    case (size)
      3'd0:    return 32'h0000_00FF << {off, 3'b000};
      3'd1:    return 32'h0000_FFFF << {off, 3'b000};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic bit isIllegal(input logic [31:0] addr, input logic [2:0] size);
    return (size > 3'd2) || ((size == 3'd1) && addr[0]) ||
           ((size == 3'd2) && (addr[1:0] != 2'b00)) || (addr[11:6] != 6'd0);
  endfunction

  task automatic resetModel();
    for (int i = 0; i < NUM_REGS; i++) begin
      model[i] = (i == 0) ? 32'hA4B0_0001 : 32'h0;
    end
  endtask

  // Drive one address phase, record its expected response, and hold until accepted.
  task automatic applyStimulus(input logic [31:0] addr, input bit wr, input logic [2:0] size,
                               input logic [31:0] wdata, input logic [1:0] trans, input logic [2:0] burst);
    exp_t        e;
    int          n;
    logic [31:0] m;
    e.wr    = wr;
    e.err   = isIllegal(addr, size);
    e.idx   = addr[5:2];
    e.rdata = model[addr[5:2]];
    if (wr && !e.err && (e.idx != 4'd0)) begin
      m = laneMask(size, addr[1:0]);
      model[e.idx] = (model[e.idx] & ~m) | (wdata & m);
    end
    sb_q.push_back(e);
    hsel   = 1'b1;
    haddr  = addr;
    htrans = trans;
    hwrite = wr;
    hsize  = size;
    hburst = burst;
    n = 0;
    do begin
      @(negedge hclk);
      n++;
    end while (!hready && n < 50);
    if (!hready) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge hclk);
    #1;
    hwdata = wdata;
    hsel   = 1'b0;
    htrans = 2'b00;
  endtask

  // Let every outstanding data phase finish, including the trailing write strobe.
  task automatic drainBus();
    int n;
    n = 0;
    hsel   = 1'b0;
    htrans = 2'b00;
    while ((sb_q.size() != 0 || active) && n < 50) begin
      @(negedge hclk);
      n++;
    end
    if (n >= 50) checkOutput("drain_timeout", 32'(sb_q.size()), 32'd0);
    repeat (2) @(posedge hclk);
    #1;
  endtask

  // Monitor: per data-phase cycle checks, plus write-strobe checks.
  always @(negedge hclk) begin
    if (hreset || !mon_en) begin
      active    = 1'b0;
      exp_pulse = 1'b0;
    end else begin
      checkOutput("wr_pulse", {31'd0, wr_pulse}, {31'd0, exp_pulse});
      if (exp_pulse) checkOutput("wr_idx", {28'd0, wr_idx}, {28'd0, exp_idx});
      exp_pulse = 1'b0;
      if (active) begin
        cyc++;
        checkOutput("hresp", {30'd0, hresp}, cur.err ? 32'd1 : 32'd0);
        if (hready) begin
          checkOutput("beat_cycles", 32'(cyc), cur.err ? 32'd2 : 32'(WS + 1));
          if (!cur.wr && !cur.err) checkOutput("hrdata", hrdata, cur.rdata);
          else                     checkOutput("hrdata_zero", hrdata, 32'd0);
          if (cur.wr && !cur.err && (cur.idx != 4'd0)) begin
            exp_pulse = 1'b1;
            exp_idx   = cur.idx;
          end
          active = 1'b0;
        end else begin
          checkOutput("hrdata_stall", hrdata, 32'd0);
          if (cyc > 20) begin
            checkOutput("beat_timeout", 32'(cyc), 32'(WS + 1));
            active = 1'b0;
          end
        end
      end
      if (hsel && htrans[1] && hready) begin
        if (sb_q.size() == 0) begin
          checkOutput("sb_underflow", 32'd0, 32'd1);
        end else begin
          cur    = sb_q.pop_front();
          active = 1'b1;
          cyc    = 0;
        end
      end
    end
  end

  initial begin
    hreset = 1'b1;
    hsel   = 1'b0;
    haddr  = 32'h0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize  = 3'd0;
    hburst = 3'd0;
    hwdata = 32'h0;
    resetModel();
    repeat (2) @(posedge hclk);
    #1;
    hreset = 1'b0;

    checkOutput("rst_hready_resp", {31'd0, hready_resp}, 32'd1);
    checkOutput("rst_hresp", {30'd0, hresp}, 32'd0);
    checkOutput("rst_hrdata", hrdata, 32'd0);
    checkOutput("rst_wr_pulse", {31'd0, wr_pulse}, 32'd0);
    checkOutput("rst_wr_idx", {28'd0, wr_idx}, 32'd0);
    mon_en = 1'b1;

    $display("[TB] ID read, word write/read, byte and half merges");
    applyStimulus(32'h00, 1'b0, 3'd2, 32'h0, 2'b10, 3'd0);
    applyStimulus(32'h14, 1'b1, 3'd2, 32'hDEAD_BEEF, 2'b10, 3'd0);
    applyStimulus(32'h14, 1'b0, 3'd2, 32'h0, 2'b10, 3'd0);
    applyStimulus(32'h15, 1'b1, 3'd0, 32'h0000_AA00, 2'b10, 3'd0);
    applyStimulus(32'h14, 1'b0, 3'd2, 32'h0, 2'b10, 3'd0);
    applyStimulus(32'h1A, 1'b1, 3'd1, 32'h1234_0000, 2'b10, 3'd0);
    applyStimulus(32'h18, 1'b0, 3'd2, 32'h0, 2'b10, 3'd0);

    $display("[TB] illegal accesses");
    applyStimulus(32'h16, 1'b1, 3'd2, 32'hFFFF_FFFF, 2'b10, 3'd0);
    applyStimulus(32'h18, 1'b1, 3'd3, 32'hFFFF_FFFF, 2'b10, 3'd0);
    applyStimulus(32'h19, 1'b1, 3'd1, 32'hFFFF_FFFF, 2'b10, 3'd0);
    applyStimulus(32'h40, 1'b1, 3'd2, 32'hFFFF_FFFF, 2'b10, 3'd0);
    applyStimulus(32'h14, 1'b0, 3'd2, 32'h0, 2'b10, 3'd0);
    applyStimulus(32'h18, 1'b0, 3'd2, 32'h0, 2'b10, 3'd0);

    $display("[TB] INCR4 bursts and reg0 write");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'h20 + 32'(4 * i), 1'b1, 3'd2, 32'(i + 1), (i == 0) ? 2'b10 : 2'b11, 3'b011);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'h20 + 32'(4 * i), 1'b0, 3'd2, 32'h0, (i == 0) ? 2'b10 : 2'b11, 3'b011);
    end
    applyStimulus(32'h00, 1'b1, 3'd2, 32'h1111_2222, 2'b10, 3'd0);
    applyStimulus(32'h00, 1'b0, 3'd2, 32'h0, 2'b10, 3'd0);

    $display("[TB] random traffic");
    for (int i = 0; i < 32; i++) begin
      applyStimulus(32'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
                    $urandom, 2'b10, 3'd0);
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      applyStimulus(32'(4 * i), 1'b0, 3'd2, 32'h0, 2'b10, 3'd0);
    end
    drainBus();

    $display("[TB] reset during a write wait state");
    mon_en = 1'b0;
    hsel   = 1'b1;
    haddr  = 32'h30;
    htrans = 2'b10;
    hwrite = 1'b1;
    hsize  = 3'd2;
    @(posedge hclk);
    #1;
    hsel   = 1'b0;
    htrans = 2'b00;
    hwdata = 32'h1234_5678;
    checkOutput("wait_ready_low", {31'd0, hready_resp}, 32'd0);
    #2;
    hreset = 1'b1;
    #1;
    checkOutput("async_ready", {31'd0, hready_resp}, 32'd1);
    checkOutput("async_hresp", {30'd0, hresp}, 32'd0);
    resetModel();
    @(posedge hclk);
    #1;
    hreset = 1'b0;
    mon_en = 1'b1;
    applyStimulus(32'h30, 1'b0, 3'd2, 32'h0, 2'b10, 3'd0);
    applyStimulus(32'h14, 1'b0, 3'd2, 32'h0, 2'b10, 3'd0);
    applyStimulus(32'h00, 1'b0, 3'd2, 32'h0, 2'b10, 3'd0);
    drainBus();

    checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
